instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue.sv | 103 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch unit: sequential PC generation feeding a circular instruction queue.
// Optional misaligned-redirect halt is enabled by defining RVSIMPLE_FETCH_MISALIGN_EN.
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h00400000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] bus_address,
  input  logic [31:0] bus_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef RVSIMPLE_FETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      q_inst [QUEUE_DEPTH];
  logic [31:0]      q_pc   [QUEUE_DEPTH];
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             halted;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

`ifdef RVSIMPLE_FETCH_MISALIGN_EN
  logic misaligned_q;

  always_ff @(posedge clock) begin
    if (reset)
      misaligned_q <= 1'b0;
    else if (redirect_valid)
      misaligned_q <= (redirect_pc[1:0] != 2'b00);
  end

  assign halted           = misaligned_q;
  assign fetch_misaligned = misaligned_q;
`else
  logic unused_redirect_low;

  assign halted              = 1'b0;
  assign unused_redirect_low = ^redirect_pc[1:0];
`endif

  always_comb begin
    bus_address = fetch_pc;
    inst_valid  = (count != '0);
    pop         = inst_valid && inst_ready;
    // A pop frees a slot in the same cycle, so a full queue still accepts a push
    push        = !reset && !redirect_valid && !halted && ((count < DEPTH_CNT) || pop);
    inst        = inst_valid ? q_inst[head] : '0;
    inst_pc     = inst_valid ? q_pc[head]   : '0;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_inst[tail] <= bus_read_data;
      q_pc[tail]   <= fetch_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail     <= next_ptr(tail);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop)
        head <= next_ptr(head);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue; also covers the
// RVSIMPLE_FETCH_MISALIGN_EN build when that macro is defined.
module tb_instruction_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h00400000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] MASK     = 32'hA5A5A5A5;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address;
  logic [31:0] bus_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef RVSIMPLE_FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_mis = 1'b0;

  always #5 clock = ~clock;

  assign bus_read_data = bus_address ^ MASK;

  instruction_fetch_queue #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_read_data    (bus_read_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .inst_pc          (inst_pc)
`ifdef RVSIMPLE_FETCH_MISALIGN_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Compare outputs against the scoreboard, advance the model by one edge, then clock.
  task automatic tick(input bit do_check);
    bit do_pop;
    bit do_push;
    if (do_check) begin
      check("bus_address", bus_address, m_pc);
      check("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("inst_pc", inst_pc, sb[0]);
        check("inst", inst, sb[0] ^ MASK);
      end else begin
        check("inst_pc_empty", inst_pc, 32'h0);
        check("inst_empty", inst, 32'h0);
      end
`ifdef RVSIMPLE_FETCH_MISALIGN_EN
      check("fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
`endif
    end
    do_pop = (sb.size() != 0) && inst_ready;
    if (reset) begin
      sb.delete();
      m_pc  = RESET_PC;
      m_mis = 1'b0;
    end else if (redirect_valid) begin
      sb.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
`ifdef RVSIMPLE_FETCH_MISALIGN_EN
      m_mis = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      do_push = !m_mis && ((sb.size() < DEPTH) || do_pop);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset          = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick(1'b0);
    tick(1'b1);

    // Streaming from reset
    reset = 1'b0;
    tick(1'b1);
    check("r032_pc0", inst_pc, 32'h00400000);
    tick(1'b1);
    check("r032_pc1", inst_pc, 32'h00400004);
    tick(1'b1);
    check("r032_pc2", inst_pc, 32'h00400008);
    tick(1'b1);

    // Stall from reset, then drain
    reset = 1'b1;
    tick(1'b1);
    reset      = 1'b0;
    inst_ready = 1'b0;
    repeat (5) tick(1'b1);
    check("r033_hold_addr", bus_address, 32'h00400008);
    check("r033_head", inst_pc, 32'h00400000);
    inst_ready = 1'b1;
    repeat (4) tick(1'b1);

    // Redirect while full with a pop
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00400100;
    check("r034_valid_before", 32'(inst_valid), 32'd1);
    tick(1'b1);
    redirect_valid = 1'b0;
    check("r034_flushed", 32'(inst_valid), 32'd0);
    tick(1'b1);
    check("r034_target", inst_pc, 32'h00400100);
    tick(1'b1);
    check("r034_next", inst_pc, 32'h00400104);
    tick(1'b1);

    // Address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    tick(1'b1);
    redirect_valid = 1'b0;
    tick(1'b1);
    check("r035_top", inst_pc, 32'hFFFFFFFC);
    tick(1'b1);
    check("r035_wrap", inst_pc, 32'h00000000);
    tick(1'b1);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00400102;
    tick(1'b1);
    redirect_valid = 1'b0;
`ifdef RVSIMPLE_FETCH_MISALIGN_EN
    check("r036_flag_set", 32'(fetch_misaligned), 32'd1);
    repeat (3) begin
      check("r036_halted", 32'(inst_valid), 32'd0);
      tick(1'b1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00400200;
    tick(1'b1);
    redirect_valid = 1'b0;
    check("r036_flag_clr", 32'(fetch_misaligned), 32'd0);
    tick(1'b1);
    check("r036_resume", inst_pc, 32'h00400200);
    tick(1'b1);
`else
    tick(1'b1);
    check("r036_ignored_low", inst_pc, 32'h00400100);
    tick(1'b1);
`endif

    // Reset beats redirect on a full queue
    inst_ready = 1'b0;
    repeat (3) tick(1'b1);
    check("r037_full", 32'(inst_valid), 32'd1);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00400300;
    inst_ready     = 1'b1;
    tick(1'b1);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    check("r037_empty", 32'(inst_valid), 32'd0);
    check("r037_pc", bus_address, RESET_PC);
    tick(1'b1);
    tick(1'b1);

    // Random traffic with occasional redirects and resets
    for (int i = 0; i < 400; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
      reset          = ($urandom_range(0, 49) == 0);
      tick(1'b1);
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    tick(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
